uart_rx_parity: RTL and testbench

//  UART receiver, the counterpart of the team's uart_tx path. Takes the serial RX

---
 rtl/uart_rx_parity.sv | 145 ++++++++++++++
 tb/tb_uart_rx_parity.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_parity.sv
// UART receiver for 8N1/8E1/8O1 frames, LSB first, with mid-bit sampling.
// Emits a one-cycle VALID strobe carrying the byte plus parity and framing error flags.
module uart_rx_parity #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       PARITY_EN,
  input  logic       PARITY_MODE,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      sh_q;
  logic            par_q;
  logic            pen_q;
  logic            pmode_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            perr_q;
  logic            ferr_q;
  logic            bit_end;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign bit_end = (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      pmode_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (!rx_s) begin
              state_q <= StData;
              pen_q   <= PARITY_EN;
              pmode_q <= PARITY_MODE;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q       <= '0;
            sh_q[idx_q] <= rx_s;
            if (idx_q == 3'd7) begin
              state_q <= pen_q ? StPar : StStop;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StPar: begin
          if (bit_end) begin
            cnt_q   <= '0;
            par_q   <= rx_s;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            // Leave at mid stop bit so a zero-gap start edge is still caught.
            cnt_q   <= '0;
            data_q  <= sh_q;
            perr_q  <= pen_q & (par_q != ((^sh_q) ^ pmode_q));
            ferr_q  <= ~rx_s;
            valid_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign DATA       = data_q;
  assign VALID      = valid_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;
  assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity: serial frames driven bit by bit, received bytes
// captured on VALID and compared against hand-computed values.
module tb_uart_rx_parity;

  localparam int unsigned Cpb  = 16;
  localparam int unsigned Sync = 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       parity_en;
  logic       parity_mode;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_vec;
  int n_err;
  int cyc;
  int t_fall;

  logic [9:0] rxq[$];
  int         latq[$];

  uart_rx_parity #(
    .CLKS_PER_BIT(Cpb),
    .SYNC_STAGES (Sync)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (rx),
    .PARITY_EN  (parity_en),
    .PARITY_MODE(parity_mode),
    .DATA       (data),
    .VALID      (valid),
    .PARITY_ERR (parity_err),
    .FRAME_ERR  (frame_err),
    .BUSY       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every strobe half a cycle after it rises.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      rxq.push_back({frame_err, parity_err, data});
      latq.push_back(cyc - t_fall);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop);
    t_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * Cpb) @(negedge clk);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic fe, input int lat);
    logic [9:0] e;
    int         l;
    if (rxq.size() == 0) begin
      chk({tag, "_valid"}, 32'd0, 32'd1);
    end else begin
      e = rxq.pop_front();
      l = latq.pop_front();
      chk({tag, "_data"}, {24'd0, e[7:0]}, {24'd0, d});
      chk({tag, "_perr"}, {31'd0, e[8]}, {31'd0, pe});
      chk({tag, "_ferr"}, {31'd0, e[9]}, {31'd0, fe});
      if (lat > 0) chk({tag, "_lat"}, {31'd0, (l >= lat - 1 && l <= lat + 1)}, 32'd1);
    end
  endtask

  initial begin
    int lat8n1;
    int lat8e1;
    n_vec       = 0;
    n_err       = 0;
    cyc         = 0;
    t_fall      = 0;
    rst_n       = 1'b0;
    rx          = 1'b1;
    parity_en   = 1'b0;
    parity_mode = 1'b0;
    lat8n1      = Sync + Cpb / 2 + 9 * Cpb + 1;
    lat8e1      = Sync + Cpb / 2 + 10 * Cpb + 1;
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 8N1
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle(1);
    expect_frame("n1_a5", 8'hA5, 1'b0, 1'b0, lat8n1);

    // Parity: 0x37 has odd weight, so even mode wants 1; 0x00 in odd mode wants 1.
    parity_en = 1'b1;
    send_frame(8'h37, 1'b1, 1'b1, 1'b1);
    idle(1);
    expect_frame("e1_37_ok", 8'h37, 1'b0, 1'b0, lat8e1);
    send_frame(8'h37, 1'b1, 1'b0, 1'b1);
    idle(1);
    expect_frame("e1_37_bad", 8'h37, 1'b1, 1'b0, 0);
    parity_mode = 1'b1;
    send_frame(8'h00, 1'b1, 1'b1, 1'b1);
    idle(1);
    expect_frame("o1_00_ok", 8'h00, 1'b0, 1'b0, 0);
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    idle(1);
    expect_frame("o1_00_bad", 8'h00, 1'b1, 1'b0, 0);
    // Flags clear again once parity is off.
    parity_en   = 1'b0;
    parity_mode = 1'b0;
    send_frame(8'hC7, 1'b0, 1'b0, 1'b1);
    idle(1);
    expect_frame("n1_c7", 8'hC7, 1'b0, 1'b0, 0);

    // Framing error then recovery
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    idle(1);
    expect_frame("fe_5a", 8'h5A, 1'b0, 1'b1, 0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    idle(1);
    expect_frame("fe_11", 8'h11, 1'b0, 1'b0, 0);
    chk("fe_extra", rxq.size(), 32'd0);

    // Start glitch
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    idle(2);
    chk("glitch_idle", {31'd0, busy}, 32'd0);
    chk("glitch_novalid", rxq.size(), 32'd0);

    // Back-to-back, zero idle gap
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("b2b_count", rxq.size(), 32'd3);
    expect_frame("b2b_01", 8'h01, 1'b0, 1'b0, 0);
    expect_frame("b2b_80", 8'h80, 1'b0, 1'b0, 0);
    expect_frame("b2b_ff", 8'hFF, 1'b0, 1'b0, lat8n1);

    // Reset in the middle of bit 4 of 0xC3; held until the frame has passed.
    begin
      logic [7:0] d;
      d = 8'hC3;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      rx = d[4];
      repeat (Cpb / 2) @(negedge clk);
      chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_data", {24'd0, data}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_flags", {30'd0, parity_err, frame_err}, 32'd0);
      repeat (Cpb / 2) @(negedge clk);
      for (int i = 5; i < 8; i++) send_bit(d[i]);
      send_bit(1'b1);
      idle(1);
      rst_n = 1'b1;
      idle(1);
      chk("rst_mid_novalid", rxq.size(), 32'd0);
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    idle(1);
    expect_frame("post_rst_3c", 8'h3C, 1'b0, 1'b0, lat8n1);
    chk("final_extra", rxq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
